// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter sharing one result bus among ALU, branch and load FIFOs
module wb_arbiter #(
  parameter int ROB_LOG = 4,
  parameter int DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic [2:0]             req_valid,
  output logic [2:0]             req_ready,
  input  logic [95:0]            req_value,
  input  logic [95:0]            req_toPC,
  input  logic [3*ROB_LOG-1:0]   req_RobId,
  output logic                   cdb_valid,
  output logic [31:0]            cdb_value,
  output logic [31:0]            cdb_toPC,
  output logic [ROB_LOG-1:0]     cdb_RobId,
  output logic [1:0]             cdb_src
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]         val_q [3][DEPTH];
  logic [31:0]         val_d [3][DEPTH];
  logic [31:0]         pc_q  [3][DEPTH];
  logic [31:0]         pc_d  [3][DEPTH];
  logic [ROB_LOG-1:0]  rid_q [3][DEPTH];
  logic [ROB_LOG-1:0]  rid_d [3][DEPTH];
  logic [PW-1:0]       wptr_q [3];
  logic [PW-1:0]       wptr_d [3];
  logic [PW-1:0]       rptr_q [3];
  logic [PW-1:0]       rptr_d [3];
  logic [CW-1:0]       cnt_q  [3];
  logic [CW-1:0]       cnt_d  [3];
  logic [1:0]          last_q, last_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [31:0]         cdb_value_q, cdb_value_d;
  logic [31:0]         cdb_toPC_q, cdb_toPC_d;
  logic [ROB_LOG-1:0]  cdb_RobId_q, cdb_RobId_d;
  logic [1:0]          cdb_src_q, cdb_src_d;

  logic [2:0]          nonempty;
  logic [2:0]          push;
  logic                pop_any;
  logic [1:0]          gnt;

  // (a + k) mod 3, used to walk the requesters starting after the last winner
  function automatic logic [1:0] wrap3(input logic [1:0] a, input int k);
    int s;
    s = int'(a) + k;
    return 2'(s % 3);
  endfunction

  // Ready depends only on registered occupancy, so a full FIFO refuses input even when popped
  always_comb begin
    nonempty = '0;
    req_ready = '0;
    push = '0;
    for (int i = 0; i < 3; i++) begin
      nonempty[i]  = (cnt_q[i] != '0);
      req_ready[i] = rst & rdy & ~flush & (cnt_q[i] != FULL);
      push[i]      = req_valid[i] & req_ready[i];
    end
  end

  // Round-robin pick: first non-empty FIFO after the most recently granted one
  always_comb begin
    gnt = 2'd0;
    pop_any = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (!pop_any && nonempty[wrap3(last_q, k)]) begin
        gnt = wrap3(last_q, k);
        pop_any = 1'b1;
      end
    end
  end

  // Next state: flush clears queues and bus valid; otherwise rdy gates push, pop and bus update
  always_comb begin
    val_d = val_q;
    pc_d = pc_q;
    rid_d = rid_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d = cnt_q;
    last_d = last_q;
    cdb_valid_d = cdb_valid_q;
    cdb_value_d = cdb_value_q;
    cdb_toPC_d = cdb_toPC_q;
    cdb_RobId_d = cdb_RobId_q;
    cdb_src_d = cdb_src_q;
    if (flush) begin
      for (int i = 0; i < 3; i++) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i] = '0;
      end
      cdb_valid_d = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) begin
          val_d[i][wptr_q[i]] = req_value[i*32 +: 32];
          pc_d[i][wptr_q[i]]  = req_toPC[i*32 +: 32];
          rid_d[i][wptr_q[i]] = req_RobId[i*ROB_LOG +: ROB_LOG];
          wptr_d[i] = wptr_q[i] + 1'b1;
        end
        cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop_any && (gnt == 2'(i)));
      end
      if (pop_any) begin
        rptr_d[gnt] = rptr_q[gnt] + 1'b1;
        cdb_valid_d = 1'b1;
        cdb_value_d = val_q[gnt][rptr_q[gnt]];
        cdb_toPC_d = pc_q[gnt][rptr_q[gnt]];
        cdb_RobId_d = rid_q[gnt][rptr_q[gnt]];
        cdb_src_d = gnt;
        last_d = gnt;
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // State registers; last starts at 2 so requester 0 is searched first after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          val_q[i][j] <= '0;
          pc_q[i][j] <= '0;
          rid_q[i][j] <= '0;
        end
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      last_q <= 2'd2;
      cdb_valid_q <= 1'b0;
      cdb_value_q <= '0;
      cdb_toPC_q <= 32'hFFFF_FFFF;
      cdb_RobId_q <= '0;
      cdb_src_q <= 2'd0;
    end else begin
      val_q <= val_d;
      pc_q <= pc_d;
      rid_q <= rid_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_value_q <= cdb_value_d;
      cdb_toPC_q <= cdb_toPC_d;
      cdb_RobId_q <= cdb_RobId_d;
      cdb_src_q <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_value = cdb_value_q;
  assign cdb_toPC = cdb_toPC_q;
  assign cdb_RobId = cdb_RobId_q;
  assign cdb_src = cdb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic         flush;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [95:0]  req_value;
  logic [95:0]  req_toPC;
  logic [11:0]  req_RobId;
  logic         cdb_valid;
  logic [31:0]  cdb_value;
  logic [31:0]  cdb_toPC;
  logic [3:0]   cdb_RobId;
  logic [1:0]   cdb_src;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.ROB_LOG(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_toPC(req_toPC), .req_RobId(req_RobId),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_toPC(cdb_toPC),
    .cdb_RobId(cdb_RobId), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] val, input logic [3:0] rid);
    req_valid[i] = v;
    req_value[i*32 +: 32] = val;
    req_toPC[i*32 +: 32] = 32'hFFFF_FFFF;
    req_RobId[i*4 +: 4] = rid;
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] src, input logic [3:0] rid);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_src"}, 64'(cdb_src), 64'(src));
    chk({tag, "_robid"}, 64'(cdb_RobId), 64'(rid));
  endtask

  logic [1:0] bp_src [6];
  logic [3:0] bp_rid [6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    req_valid = '0; req_value = '0; req_toPC = '1; req_RobId = '0;

    // reset state
    tick();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_topc", 64'(cdb_toPC), 64'hFFFF_FFFF);
    chk("rst_robid", 64'(cdb_RobId), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b111);

    // single ALU result
    drive(0, 1'b1, 32'h12, 4'd5);
    #1;
    chk("single_ready0", 64'(req_ready[0]), 64'd1);
    tick();
    drive(0, 1'b0, 32'h0, 4'd0);
    chk("single_lat_valid", 64'(cdb_valid), 64'd0);
    tick();
    chk_bus("single", 2'd0, 4'd5);
    chk("single_value", 64'(cdb_value), 64'h12);
    chk("single_topc", 64'(cdb_toPC), 64'hFFFF_FFFF);
    tick();
    chk("single_pulse", 64'(cdb_valid), 64'd0);
    chk("single_hold_value", 64'(cdb_value), 64'h12);

    // three-way contention right after reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'(100 + i), 4'(1 + i));
    tick();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 4'd0);
    tick(); chk_bus("cont0", 2'd0, 4'd1);
    tick(); chk_bus("cont1", 2'd1, 4'd2);
    tick(); chk_bus("cont2", 2'd2, 4'd3);
    tick(); chk("cont_idle", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'(200 + i), 4'(4 + i));
    tick();
    chk("contc_first", 64'(cdb_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_bus($sformatf("contc%0d", k), 2'(k % 3), 4'(4 + (k % 3)));
    end
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 4'd0);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_a_valid", 64'(cdb_valid), 64'd0);
    tick();
    chk("flush_a_empty", 64'(cdb_valid), 64'd0);

    // backpressure on the load FIFO
    bp_src = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    bp_rid = '{4'd1, 4'd2, 4'd11, 4'd1, 4'd2, 4'd12};
    drive(0, 1'b1, 32'hA0, 4'd1);
    drive(1, 1'b1, 32'hB0, 4'd2);
    drive(2, 1'b1, 32'hC0, 4'd10);
    tick();
    chk("bp_e1_valid", 64'(cdb_valid), 64'd0);
    drive(2, 1'b1, 32'hC1, 4'd11);
    tick();
    chk_bus("bp_e2", 2'd0, 4'd1);
    chk("bp_e2_ready2", 64'(req_ready[2]), 64'd0);
    drive(2, 1'b1, 32'hC2, 4'd12);
    tick();
    chk_bus("bp_e3", 2'd1, 4'd2);
    chk("bp_e3_ready2", 64'(req_ready[2]), 64'd0);
    tick();
    chk_bus("bp_e4", 2'd2, 4'd10);
    chk("bp_e4_ready2", 64'(req_ready[2]), 64'd1);
    tick();
    chk_bus("bp_e5", 2'd0, 4'd1);
    chk("bp_e5_ready2", 64'(req_ready[2]), 64'd0);
    drive(2, 1'b0, 32'h0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick();
        chk_bus($sformatf("bp_e%0d", k + 5), bp_src[k], bp_rid[k]);
      end
    end
    chk("bp_value12", 64'(cdb_value), 64'hC2);
    drive(0, 1'b0, 32'h0, 4'd0);
    drive(1, 1'b0, 32'h0, 4'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("bp_flush_valid", 64'(cdb_valid), 64'd0);

    // flush discards queued branch results
    drive(0, 1'b1, 32'h33, 4'd3);
    drive(1, 1'b1, 32'h99, 4'd9);
    tick();
    drive(0, 1'b0, 32'h0, 4'd0);
    drive(1, 1'b1, 32'h13, 4'd13);
    tick();
    chk_bus("fl_alu", 2'd0, 4'd3);
    drive(1, 1'b0, 32'h0, 4'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid0", 64'(cdb_valid), 64'd0);
    tick();
    chk("fl_valid1", 64'(cdb_valid), 64'd0);
    tick();
    chk("fl_valid2", 64'(cdb_valid), 64'd0);
    drive(1, 1'b1, 32'h14, 4'd14);
    tick();
    drive(1, 1'b0, 32'h0, 4'd0);
    chk("fl_new_lat", 64'(cdb_valid), 64'd0);
    tick();
    chk_bus("fl_new", 2'd1, 4'd14);

    // rdy stall holds the bus
    drive(0, 1'b1, 32'h77, 4'd7);
    tick();
    drive(0, 1'b1, 32'h88, 4'd8);
    tick();
    chk_bus("stall_pre", 2'd0, 4'd7);
    rdy = 1'b0;
    drive(0, 1'b1, 32'h55, 4'd9);
    #1;
    chk("stall_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bus($sformatf("stall%0d", k), 2'd0, 4'd7);
    end
    rdy = 1'b1;
    drive(0, 1'b0, 32'h0, 4'd0);
    tick();
    chk_bus("stall_after", 2'd0, 4'd8);
    chk("stall_after_value", 64'(cdb_value), 64'h88);
    tick();
    chk("stall_no_push", 64'(cdb_valid), 64'd0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'(300 + i), 4'(1 + i));
    tick();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 4'd0);
    tick();
    chk_bus("ar_pre", 2'd1, 4'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 64'(cdb_valid), 64'd0);
    chk("ar_robid", 64'(cdb_RobId), 64'd0);
    chk("ar_topc", 64'(cdb_toPC), 64'hFFFF_FFFF);
    chk("ar_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("ar_stale0", 64'(cdb_valid), 64'd0);
    tick();
    chk("ar_stale1", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < 3; i++) drive(i, 1'b1, 32'(400 + i), 4'(4 + i));
    tick();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 4'd0);
    tick();
    chk_bus("ar_first", 2'd0, 4'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Result-bus arbiter that shares the ROB's single execute writeback port (`exc_valid/exc_value/exc_toPC/exc_RobId`) among three execution requesters: ALU (0), branch/jump unit (1) and load unit (2). Each requester gets a small FIFO with a valid/ready handshake. Granting is round-robin, and the selected result is registered onto one common data bus. The same bus feeds the ROB and the RS/LSB operand-forwarding snoop. A mispredict flush (`jump_flag` from ROB commit) discards everything still in flight.

## Interface
Parameters:
- `ROB_LOG`, default 4: width of ROB entry ids.
- `DEPTH`, default 2: entries per requester FIFO; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `rdy`  in  1  global enable; 0 freezes all state.
- `flush`  in  1  synchronous flush, tied to ROB `jump_flag`.
- `req_valid[i]`, i=0..2  in  1 each  requester i offers a result.
- `req_ready[i]`  out  1 each  requester i result accepted this edge if valid.
- `req_value[i]`  in  32 each  result value.
- `req_toPC[i]`  in  32 each  redirect target; 32'hFFFFFFFF = no redirect.
- `req_RobId[i]`  in  ROB_LOG each  destination ROB entry.
- `cdb_valid`  out  1  bus carries a result this cycle.
- `cdb_value`  out  32  broadcast value.
- `cdb_toPC`  out  32  broadcast redirect target.
- `cdb_RobId`  out  ROB_LOG  broadcast ROB id.
- `cdb_src`  out  2  index of granted requester (debug/verification).

## Operation
- Per requester: circular FIFO of DEPTH entries, each {value, toPC, RobId}.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
- `req_ready[i] = rdy & ~flush & (count_i != DEPTH)`. This is combinational from registered count only. A full FIFO rejects input even in a cycle where it is also popped.
- Push: on an edge with `req_valid[i] & req_ready[i]`, the entry is written at wptr_i and wptr_i increments.
- Arbitration: combinational over non-empty FIFOs.
  - Search order starts at `(last + 1) mod 3`, then wraps: last+1, last+2, last.
  - `last` is a 2-bit register holding the most recently granted index; legal values are 0..2.
- Grant edge, when any FIFO is non-empty and `rdy & ~flush`:
  - The head of the granted FIFO is popped and copied into the cdb registers.
  - `cdb_valid<=1`, `cdb_src<=g`, `last<=g`.
- No FIFO non-empty: `cdb_valid<=0`. The other cdb fields hold their previous values.
- The same FIFO may push and pop on one edge; count is unchanged.
- Flush edge (`flush=1`, `rdy=1`):
  - All counts and pointers go to 0 and `cdb_valid<=0`.
  - No push, no pop; `last` is unchanged.
- `rdy=0`: no push, no pop, and all registers hold, including `cdb_valid`. The ROB ignores the bus while `rdy=0`.
- Priority: reset overrides flush, and flush overrides rdy gating.
- The block does not interpret toPC; it passes it through unchanged.

## Timing
- Reset (rst=0, asynchronous):
  - `cdb_valid=0`, `cdb_value=0`, `cdb_toPC=32'hFFFFFFFF`, `cdb_RobId=0`, `cdb_src=0`.
  - All FIFOs empty; `last=2`, so requester 0 has highest priority first.
  - `req_ready` reads 0 while in reset.
- Latency: a result accepted at edge k is at the head of an otherwise empty FIFO. If granted, it appears on the bus (`cdb_valid=1`) in the cycle after edge k+1, i.e. 1 cycle in the FIFO, then registered output.
- Throughput: one result per cycle total. Under continuous contention each requester gets 1 of every 3 grants.
- `cdb_valid` is a single-cycle pulse per result unless `rdy=0` stretches it.
- Flush and a new `req_valid` in the same cycle: the input is dropped, because `req_ready=0`. The requester must also be flushed by the same `jump_flag`.
- Reset released mid-stream: everything restarts from the reset state; no stale entries survive.

## Test plan
- Single ALU result:
  - Stimulus: `req_valid[0]=1` for one cycle, value=32'h12, toPC=32'hFFFFFFFF, RobId=5.
  - Response: `req_ready[0]=1`, and one edge later `cdb_valid=1`, value 32'h12, RobId 5, `cdb_src=0` for exactly one cycle.
- Three-way contention:
  - Stimulus: all three requesters valid on the same edge (RobIds 1, 2, 3), immediately after reset.
  - Response: bus order is src 0, 1, 2 on consecutive cycles. Then, with continuous valid inputs, the order repeats 0, 1, 2.
- Backpressure:
  - Stimulus: the load unit pushes 3 results on back-to-back cycles while ALU and branch keep their FIFOs non-empty.
  - Response: `req_ready[2]` drops to 0 when count reaches 2. No result is lost or duplicated; load RobIds appear on the bus in push order.
- Flush:
  - Stimulus: 2 entries queued in FIFO 1, then `flush=1` for one cycle.
  - Response: `cdb_valid=0` the next cycle, and no RobId from FIFO 1 is ever broadcast. A new push afterwards appears 1 cycle later.
- rdy stall:
  - Stimulus: `rdy=0` for 3 cycles while `cdb_valid=1` with RobId 7 and FIFO 0 holds RobId 8.
  - Response: the bus holds RobId 7 and no push is accepted. RobId 8 appears on the first grant edge after `rdy` returns to 1.
- Async reset mid-operation:
  - Stimulus: assert `rst=0` between clock edges while FIFOs are partly full.
  - Response: `cdb_valid` goes to 0 immediately with all counts 0. After release, requester 0 wins the first contention.
